// File: rtl/cfg_serial_loader_pkg.sv
// Shared definitions for the configuration serial loader: FSM state
// encoding, frame mode constants and a small sizing helper.
package cfg_serial_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_ERR    = 3'd4
   } state_t;

   localparam logic MODE_DATA_ONLY = 1'b0;
   localparam logic MODE_ADDR_DATA = 1'b1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cfg_serial_loader_if.sv
// Serial command line in, committed configuration word out.
// Handshake: an input bit is transferred only in a cycle with ValidCmd = 1
// (no back-pressure); CfgValid and Error are single-cycle strobes that are
// never high together, and Cfg* hold their values between commits.
interface cfg_serial_loader_if
   import cfg_serial_loader_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              ValidCmd;
   logic              InputKey;
   logic              Active;
   logic              Mode;
   logic [ADDR_W-1:0] CfgAddr;
   logic [DATA_W-1:0] CfgData;
   logic              CfgMode;
   logic              CfgValid;
   logic              Busy;
   logic              Error;
   state_t            DbgState;

   modport master (
      output ValidCmd, InputKey, Active, Mode,
      input  CfgAddr, CfgData, CfgMode, CfgValid, Busy, Error, DbgState
   );

   modport slave (
      input  ValidCmd, InputKey, Active, Mode,
      output CfgAddr, CfgData, CfgMode, CfgValid, Busy, Error, DbgState
   );
endinterface

// File: rtl/cfg_serial_loader_serial_field_shifter.sv
// MSB-first shift register for one frame field with a bit counter.
// o_complete flags the cycle in which the final bit of the field is shifted.
module serial_field_shifter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_shift,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_value,
   output logic             o_complete
);
   logic [WIDTH-1:0] r_sh;
   logic [CNT_W-1:0] r_cnt;

   assign o_value    = r_sh;
   assign o_complete = i_shift && (r_cnt == CNT_W'(WIDTH - 1));

   // Shift in qualified bits; the counter restarts after each full field.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh  <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sh  <= WIDTH'({r_sh, i_bit});
         r_cnt <= o_complete ? '0 : r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/cfg_serial_loader.sv
// Captures the address/data configuration frame that follows a decoded key
// and commits it as a parallel word with a CfgValid strobe. Line silence or
// loss of Active abort the frame with an Error strobe.
module cfg_serial_loader
   import cfg_serial_loader_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   cfg_serial_loader_if.slave bus
);
   localparam int CNT_W = $clog2(max2(ADDR_W, DATA_W) + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   state_t            r_state, w_state_nxt;
   logic              r_active_q;
   logic              r_mode_q;
   logic [TO_W-1:0]   r_to_cnt;
   logic [ADDR_W-1:0] r_cfg_addr;
   logic [DATA_W-1:0] r_cfg_data;
   logic              r_cfg_mode;

   logic              w_rise;
   logic              w_timeout;
   logic              w_in_frame;
   logic              w_commit;
   logic [ADDR_W-1:0] w_addr_sh;
   logic [DATA_W-1:0] w_data_sh;
   logic [DATA_W-1:0] w_data_word;
   logic              w_addr_done;
   logic              w_data_done;

   assign w_rise      = bus.Active && !r_active_q;
   assign w_in_frame  = (r_state == ST_ADDR) || (r_state == ST_DATA);
   assign w_timeout   = !bus.ValidCmd && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign w_commit    = (r_state == ST_DATA) && (w_state_nxt == ST_COMMIT);
   assign w_data_word = DATA_W'({w_data_sh, bus.InputKey});

   serial_field_shifter #(.WIDTH(ADDR_W), .CNT_W(CNT_W)) u_addr_sh (
      .i_clk      (Clk),
      .i_rst_n    (Reset),
      .i_clear    (r_state == ST_IDLE),
      .i_shift    (bus.ValidCmd && (r_state == ST_ADDR)),
      .i_bit      (bus.InputKey),
      .o_value    (w_addr_sh),
      .o_complete (w_addr_done)
   );

   serial_field_shifter #(.WIDTH(DATA_W), .CNT_W(CNT_W)) u_data_sh (
      .i_clk      (Clk),
      .i_rst_n    (Reset),
      .i_clear    (r_state == ST_IDLE),
      .i_shift    (bus.ValidCmd && (r_state == ST_DATA)),
      .i_bit      (bus.InputKey),
      .o_value    (w_data_sh),
      .o_complete (w_data_done)
   );

   // State register and registered copy of Active for edge detection.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= ST_IDLE;
         r_active_q <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_active_q <= bus.Active;
      end
   end

   // Next state: losing Active beats everything, a bit beats the timeout.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rise) w_state_nxt = (bus.Mode == MODE_ADDR_DATA) ? ST_ADDR : ST_DATA;
         end
         ST_ADDR: begin
            if (!bus.Active)      w_state_nxt = ST_ERR;
            else if (w_addr_done) w_state_nxt = ST_DATA;
            else if (w_timeout)   w_state_nxt = ST_ERR;
         end
         ST_DATA: begin
            if (!bus.Active)      w_state_nxt = ST_ERR;
            else if (w_data_done) w_state_nxt = ST_COMMIT;
            else if (w_timeout)   w_state_nxt = ST_ERR;
         end
         ST_COMMIT: w_state_nxt = ST_IDLE;
         ST_ERR:    w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Latch the frame mode on the Active rising edge seen in IDLE.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)                           r_mode_q <= 1'b0;
      else if (r_state == ST_IDLE && w_rise) r_mode_q <= bus.Mode;
   end

   // Silence counter: counts idle cycles inside a frame, saturating.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)                                  r_to_cnt <= '0;
      else if (!w_in_frame || bus.ValidCmd)        r_to_cnt <= '0;
      else if (r_to_cnt != TO_W'(TIMEOUT_CYC))     r_to_cnt <= r_to_cnt + 1'b1;
   end

   // Commit the completed frame; the address only updates for addr+data frames.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cfg_addr <= '0;
         r_cfg_data <= '0;
         r_cfg_mode <= 1'b0;
      end else if (w_commit) begin
         r_cfg_data <= w_data_word;
         r_cfg_mode <= r_mode_q;
         if (r_mode_q == MODE_ADDR_DATA) r_cfg_addr <= w_addr_sh;
      end
   end

   assign bus.CfgAddr  = r_cfg_addr;
   assign bus.CfgData  = r_cfg_data;
   assign bus.CfgMode  = r_cfg_mode;
   assign bus.CfgValid = (r_state == ST_COMMIT);
   assign bus.Error    = (r_state == ST_ERR);
   assign bus.Busy     = w_in_frame;
   assign bus.DbgState = r_state;
endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed plus randomized bench for cfg_serial_loader.
module tb_cfg_serial_loader;
   import cfg_serial_loader_pkg::*;

   localparam int ADDR_W      = 4;
   localparam int DATA_W      = 8;
   localparam int TIMEOUT_CYC = 16;
   localparam int W           = 1 + ADDR_W + DATA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cfg_serial_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   cfg_serial_loader #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus_if)
   );

   // ---------------- scoreboard / model ----------------
   int total = 0;
   int bad   = 0;
   logic              m_mode;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic [W-1:0]      exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cfg(input string tag);
      chk(tag, 32'({bus_if.CfgMode, bus_if.CfgAddr, bus_if.CfgData}),
               32'({m_mode, m_addr, m_data}));
   endtask

   // Strobe/flag triple {CfgValid, Error, Busy}.
   task automatic chk_flags(input string tag, input logic [2:0] exp);
      chk(tag, 32'({bus_if.CfgValid, bus_if.Error, bus_if.Busy}), 32'(exp));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic bit_of(input logic mode, input logic [ADDR_W-1:0] a,
                                   input logic [DATA_W-1:0] d, input int i);
      if (mode && i < ADDR_W) return a[ADDR_W-1-i];
      return d[DATA_W-1-(i - (mode ? ADDR_W : 0))];
   endfunction

   task automatic start_frame(input logic mode);
      bus_if.ValidCmd = 1'b0;
      bus_if.Active   = 1'b0;
      tick();
      bus_if.Active = 1'b1;
      bus_if.Mode   = mode;
      tick();
      bus_if.Mode = 1'($urandom_range(0, 1));
      chk_flags("start_busy", 3'b001);
   endtask

   task automatic send_bit(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         bus_if.InputKey = 1'($urandom_range(0, 1));
         tick();
         chk_flags("gap_busy", 3'b001);
      end
      bus_if.ValidCmd = 1'b1;
      bus_if.InputKey = b;
      tick();
      bus_if.ValidCmd = 1'b0;
      bus_if.InputKey = 1'($urandom_range(0, 1));
   endtask

   task automatic full_frame(input logic mode, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int gap_lo, input int gap_hi);
      int n;
      logic [W-1:0] e;
      n = mode ? (ADDR_W + DATA_W) : DATA_W;
      exp_q.push_back({mode, (mode ? a : m_addr), d});
      start_frame(mode);
      for (int i = 0; i < n; i++) begin
         send_bit(bit_of(mode, a, d, i), $urandom_range(gap_lo, gap_hi));
         if (i < n - 1) chk_flags("bit_busy", 3'b001);
      end
      chk_flags("commit_strobe", 3'b100);
      e = exp_q.pop_front();
      {m_mode, m_addr, m_data} = e;
      chk_cfg("commit_cfg");
      tick();
      chk_flags("commit_one_cycle", 3'b000);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int strobes;
      bus_if.ValidCmd = 1'b0;
      bus_if.InputKey = 1'b0;
      bus_if.Active   = 1'b0;
      bus_if.Mode     = 1'b0;
      {m_mode, m_addr, m_data} = '0;
      rst_n = 1'b0;

      // 1. reset state
      tick();
      chk_flags("rst_flags", 3'b000);
      chk_cfg("rst_cfg");
      tick();
      rst_n = 1'b1;
      tick();
      chk_flags("rst_release_idle", 3'b000);
      chk("rst_state", 32'(bus_if.DbgState), 32'(ST_IDLE));

      // 2. data-only frame 0xA5
      full_frame(MODE_DATA_ONLY, 4'h0, 8'hA5, 0, 0);
      chk("t2_data", 32'(bus_if.CfgData), 32'h00A5);

      // 3. addr+data frame with 2-cycle gaps, then no re-trigger
      full_frame(MODE_ADDR_DATA, 4'h3, 8'h5C, 2, 2);
      strobes = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus_if.CfgValid || bus_if.Busy) strobes++;
      end
      chk("t3_no_retrigger", 32'(strobes), 32'd0);

      // 4a. timeout after 16 silent cycles
      start_frame(MODE_DATA_ONLY);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 0);
      for (int k = 1; k < TIMEOUT_CYC; k++) begin
         tick();
         chk_flags("t4_waiting", 3'b001);
      end
      tick();
      chk_flags("t4_error", 3'b010);
      chk_cfg("t4_cfg_held");
      chk("t4_data_5c", 32'(bus_if.CfgData), 32'h005C);
      tick();
      chk_flags("t4_error_one_cycle", 3'b000);

      // 4b. bits landing on the 15th/16th silent cycle keep the frame alive
      full_frame(MODE_DATA_ONLY, 4'h0, 8'($urandom), TIMEOUT_CYC - 2, TIMEOUT_CYC - 1);

      // 5a. Active dropped after 6 bits
      start_frame(MODE_ADDR_DATA);
      for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 0);
      bus_if.Active = 1'b0;
      tick();
      chk_flags("t5a_error", 3'b010);
      chk_cfg("t5a_cfg_held");
      tick();
      chk_flags("t5a_error_one_cycle", 3'b000);

      // 5b. Active dropped together with the final data bit
      start_frame(MODE_ADDR_DATA);
      for (int i = 0; i < ADDR_W + DATA_W - 1; i++) send_bit(1'($urandom_range(0, 1)), 0);
      bus_if.ValidCmd = 1'b1;
      bus_if.InputKey = 1'b1;
      bus_if.Active   = 1'b0;
      tick();
      bus_if.ValidCmd = 1'b0;
      chk_flags("t5b_abort_wins", 3'b010);
      chk_cfg("t5b_cfg_held");
      tick();
      chk_flags("t5b_after", 3'b000);

      // 6. asynchronous reset in the middle of data bit 5
      start_frame(MODE_DATA_ONLY);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0);
      bus_if.ValidCmd = 1'b1;
      bus_if.InputKey = 1'b1;
      #2;
      rst_n = 1'b0;
      bus_if.Active = 1'b0;
      #1;
      {m_mode, m_addr, m_data} = '0;
      chk_flags("t6_async_flags", 3'b000);
      chk_cfg("t6_async_cfg");
      chk("t6_async_state", 32'(bus_if.DbgState), 32'(ST_IDLE));
      @(posedge clk);
      #2;
      bus_if.ValidCmd = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_flags("t6_no_error", 3'b000);
      end
      full_frame(MODE_DATA_ONLY, 4'h0, 8'hFF, 0, 1);
      chk("t6_addr_zero", 32'(bus_if.CfgAddr), 32'd0);

      // random frames
      for (int r = 0; r < 10; r++)
         full_frame(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom), 0, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop guard so the run always terminates.
   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cfg_serial_loader.md
Name: cfg_serial_loader

Overview:
- Sits directly downstream of the key decoder, sharing the same serial command line (ValidCmd / InputKey).
- When the decoder raises Active, this block captures the configuration frame that follows the key. Mode = 0 selects a data-only frame; Mode = 1 selects an address-plus-data frame.
- Each completed frame is presented as a parallel word with a one-cycle CfgValid strobe to the rest of the controller.
- Frames are aborted with an Error strobe on line silence or loss of Active.

Parameters:
DATA_W, 8, width of data field (bits shifted MSB first)
ADDR_W, 4, width of address field (Mode = 1 frames only)
TIMEOUT_CYC, 16, consecutive cycles without ValidCmd that abort a frame in progress

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
ValidCmd  input  1  qualifies InputKey for one cycle
InputKey  input  1  serial data bit
Active  input  1  from key decoder; rising edge starts a frame
Mode  input  1  from key decoder; sampled on Active rising edge
CfgAddr  output  ADDR_W  last committed address
CfgData  output  DATA_W  last committed data
CfgMode  output  1  mode of last committed frame
CfgValid  output  1  one-cycle strobe, commit
Busy  output  1  frame in progress (ADDR or DATA state)
Error  output  1  one-cycle strobe, frame aborted

Behaviour:
- Reset (Reset = 0, asynchronous): state IDLE; all outputs 0; shift registers, bit counter, timeout counter and ActiveQ all 0.
- ActiveQ is a registered copy of Active. A rising edge is Active = 1 & ActiveQ = 0.
- IDLE:
  - On a rising edge, latch Mode into ModeQ.
  - Next state is ADDR if Mode = 1, otherwise DATA.
  - Clear the bit counter and timeout counter.
  - ValidCmd in IDLE is ignored, including in the edge cycle.
- ADDR:
  - Each cycle with ValidCmd = 1: AddrSh <= {AddrSh[ADDR_W-2:0], InputKey}; bit counter +1.
  - When the ADDR_W-th bit is sampled, go to DATA and clear the bit counter.
- DATA:
  - Same shifting into DataSh.
  - When the DATA_W-th bit is sampled in cycle N:
    - On the clock edge ending N, CfgData <= DataSh shifted with the final bit, CfgMode <= ModeQ, and CfgAddr <= AddrSh only if ModeQ = 1 (otherwise CfgAddr holds its value).
    - State goes to COMMIT.
- COMMIT: lasts exactly one cycle (N+1), with CfgValid = 1; then returns to IDLE.
- Latency: last bit sampled in cycle N → CfgValid and the new Cfg* values visible in cycle N+1.
- No re-trigger: Active still high after a commit does not start a new frame. A new frame needs Active low for at least one cycle, then high again.
- Timeout (ADDR/DATA only):
  - The counter clears on state entry and on each ValidCmd = 1 cycle, and increments on each cycle with ValidCmd = 0.
  - When it reaches TIMEOUT_CYC-1 with ValidCmd = 0, the next state is ERR.
  - Result: Error is high in the cycle after TIMEOUT_CYC consecutive idle cycles.
- Active = 0 while in ADDR/DATA: next state is ERR.
- Simultaneous events in the same cycle:
  - ValidCmd = 1 with the timeout threshold: the bit wins and the counter clears.
  - Active = 0 with the final bit: the abort wins, ERR, no commit.
- ERR:
  - Lasts one cycle with Error = 1, then returns to IDLE.
  - CfgAddr, CfgData and CfgMode keep their previous committed values.
  - CfgValid and Error are never high in the same cycle.
- Busy = 1 exactly in ADDR and DATA states.
- Outputs are registered or decoded directly from the state register, so there are no combinational paths from inputs to outputs.
- Width rules:
  - Bit counter width: $clog2(max(ADDR_W, DATA_W)+1).
  - Timeout counter width: $clog2(TIMEOUT_CYC+1). The counter saturates and never wraps.
- Reset mid-frame: immediate return to IDLE and zeroed outputs. A partial frame is discarded without an Error strobe.

Decomposition:
- Shared controller package holds:
  - the state encoding (IDLE, ADDR, DATA, COMMIT, ERR);
  - the MODE_DATA_ONLY = 0 and MODE_ADDR_DATA = 1 constants.
- One natural sub-module: serial_field_shifter.
  - Parameterised width; contains the shift register, the bit counter, and a "field complete" flag.
  - Instantiated twice, once for address and once for data.
- The timeout counter and FSM stay in the top level.

Test Plan (DATA_W = 8, ADDR_W = 4, TIMEOUT_CYC = 16):
1. Assert Reset = 0 asynchronously mid-cycle → all outputs 0 immediately; release → IDLE, Busy = 0.
2. Active 0→1 with Mode = 0, then 8 ValidCmd bits 1,0,1,0,0,1,0,1 on consecutive cycles → Busy = 1 during bits; CfgValid = 1 for exactly one cycle after the last bit; CfgData = 0xA5, CfgMode = 0, CfgAddr = 0.
3. Active rise with Mode = 1, then bits 0011 then 01011100, with 2-cycle gaps between bits → CfgAddr = 0x3, CfgData = 0x5C, CfgMode = 1; holding Active high afterward gives no second CfgValid.
4. Mode = 0 frame, 3 bits, then ValidCmd = 0 for 16 cycles → Error = 1 for one cycle on the 17th cycle, Busy = 0, CfgData still 0x5C; a ValidCmd on cycle 15 instead resets the count and the frame completes.
5. Mode = 1 frame: drop Active after 6 bits → Error one cycle later; in a separate run, drop Active in the same cycle as the final data bit → Error, no CfgValid, Cfg* unchanged.
6. Reset = 0 during DATA bit 5, then release and run a new Mode = 0 frame of 0xFF → no Error strobe on abort; CfgData = 0xFF, CfgAddr = 0.
